// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl: instruction sequencer for core.inst.
// For each kernel index kij it streams col weight rows into L0 (load), then
// len_nij activation rows (execute), then one flush cycle. A drain engine in
// parallel writes every ofifo_valid beat into psum memory at consecutive
// addresses until len_nij*num_kij psums have been stored.
//
// Optional build macro: CORE_SEQ_PERF_EN adds the stall_cnt/run_cnt outputs.
//
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous active-low reset
//   start        one-cycle pulse, sampled only while idle
//   num_kij      kernel positions to run (clamped to max_kij), latched on start
//   l0_ready     L0 can accept a row this cycle
//   ofifo_valid  OFIFO holds a psum row
//   inst         50-bit core instruction word (registered)
//   busy         high from the cycle after an accepted start until done
//   done         one-cycle completion pulse
//   stall_cnt    (CORE_SEQ_PERF_EN) cycles in WLOAD/ACT with l0_ready low
//   run_cnt      (CORE_SEQ_PERF_EN) cycles with busy high
module core_seq_ctrl #(
  parameter int unsigned col     = 8,
  parameter int unsigned len_nij = 1024,
  parameter int unsigned max_kij = 9,
  parameter logic [10:0] wbase   = 11'h400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  num_kij,
  input  logic        l0_ready,
  input  logic        ofifo_valid,
  output logic [49:0] inst,
  output logic        busy,
  output logic        done
`ifdef CORE_SEQ_PERF_EN
  ,
  output logic [15:0] stall_cnt,
  output logic [23:0] run_cnt
`endif
);

  localparam int unsigned ROW_W = $clog2((len_nij > col) ? len_nij : col);
  localparam int unsigned CNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WLOAD,
    S_ACT,
    S_FLUSH,
    S_DRAIN
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         kij_q, kij_d;
  logic [3:0]         nkij_q, nkij_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [CNT_W-1:0]   target_q, target_d;
  logic [CNT_W-1:0]   drain_cnt_q;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               start_ok;
  logic [3:0]         nk_clamped;

  // Issue decision for the current cycle
  logic               cen0_d;
  logic [10:0]        a0_d;
  logic [2:0]         lem_d;     // {mode, execute, load}
  logic               pm_wr_d;

  // Instruction field registers
  logic               cen0_q;
  logic [10:0]        a0_q;
  logic               pm_wr_q;
  logic [13:0]        apm_q;
  logic [2:0]         lem_p1, lem_p2, lem_q;
  logic               l0_wr_q, l0_rd_q;

  assign nk_clamped = (num_kij > 4'(max_kij)) ? 4'(max_kij) : num_kij;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      kij_q    <= '0;
      nkij_q   <= '0;
      row_q    <= '0;
      target_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      kij_q    <= kij_d;
      nkij_q   <= nkij_d;
      row_q    <= row_d;
      target_q <= target_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    kij_d    = kij_q;
    nkij_d   = nkij_q;
    row_d    = row_q;
    target_d = target_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    start_ok = 1'b0;
    cen0_d   = 1'b1;
    a0_d     = '0;
    lem_d    = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          start_ok = 1'b1;
          if (nk_clamped == 4'd0) begin
            done_d = 1'b1;
          end else begin
            state_d  = S_WLOAD;
            kij_d    = '0;
            row_d    = '0;
            nkij_d   = nk_clamped;
            target_d = CNT_W'(len_nij * nk_clamped);
            busy_d   = 1'b1;
          end
        end
      end
      S_WLOAD: begin
        if (l0_ready) begin
          cen0_d = 1'b0;
          a0_d   = 11'(wbase + kij_q * col + row_q);
          lem_d  = 3'b001;
          if (row_q == ROW_W'(col - 1)) begin
            row_d   = '0;
            state_d = S_ACT;
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end
      end
      S_ACT: begin
        if (l0_ready) begin
          cen0_d = 1'b0;
          a0_d   = 11'(row_q);
          lem_d  = 3'b010;
          if (row_q == ROW_W'(len_nij - 1)) begin
            row_d   = '0;
            state_d = S_FLUSH;
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end
      end
      S_FLUSH: begin
        lem_d = 3'b111;
        kij_d = kij_q + 4'd1;
        if ((kij_q + 4'd1) < nkij_q) state_d = S_WLOAD;
        else                         state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // drain_cnt_q is already registered, so the final pmem write is
        // on inst at least one cycle before done rises.
        if (drain_cnt_q >= target_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Drain engine: independent of the issue FSM, stops at the target count.
  assign pm_wr_d = busy_q & ofifo_valid & (drain_cnt_q < target_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drain_cnt_q <= '0;
    end else if (start_ok) begin
      drain_cnt_q <= '0;
    end else if (pm_wr_d) begin
      drain_cnt_q <= drain_cnt_q + CNT_W'(1);
    end
  end

  // Memory fields register once; load/execute/mode pass two extra stages so
  // they line up with xmem read data reaching L0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cen0_q  <= 1'b1;
      a0_q    <= '0;
      pm_wr_q <= 1'b0;
      apm_q   <= '0;
      lem_p1  <= '0;
      lem_p2  <= '0;
      lem_q   <= '0;
      l0_wr_q <= 1'b0;
      l0_rd_q <= 1'b0;
    end else begin
      cen0_q  <= cen0_d;
      a0_q    <= a0_d;
      pm_wr_q <= pm_wr_d;
      apm_q   <= drain_cnt_q[13:0];
      lem_p1  <= lem_d;
      lem_p2  <= lem_p1;
      lem_q   <= lem_p2;
      l0_wr_q <= ~cen0_q;  // WEN0 is always 1, so only CEN0 matters
      l0_rd_q <= l0_wr_q;
    end
  end

  assign inst = {1'b0,          // [49]    acc
                 ~pm_wr_q,      // [48]    CEN_pmem
                 ~pm_wr_q,      // [47]    WEN_pmem
                 apm_q,         // [46:33] A_pmem
                 1'b1,          // [32]    CEN1_xmem
                 11'd0,         // [31:21] A1_xmem
                 cen0_q,        // [20]    CEN0_xmem
                 1'b1,          // [19]    WEN0_xmem
                 a0_q,          // [18:8]  A0_xmem
                 pm_wr_q,       // [7]     ofifo_rd
                 2'b00,         // [6:5]   ififo_wr/ififo_rd
                 l0_rd_q,       // [4]     l0_rd
                 l0_wr_q,       // [3]     l0_wr
                 lem_q};        // [2:0]   mode/execute/load

  assign busy = busy_q;
  assign done = done_q;

`ifdef CORE_SEQ_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      run_cnt   <= '0;
    end else if (start_ok) begin
      stall_cnt <= '0;
      run_cnt   <= '0;
    end else begin
      if ((state_q == S_WLOAD || state_q == S_ACT) && !l0_ready && stall_cnt != '1)
        stall_cnt <= stall_cnt + 16'd1;
      if (busy_q && run_cnt != '1)
        run_cnt <= run_cnt + 24'd1;
    end
  end
`endif

endmodule

// File: tb/tb_core_seq_ctrl.sv
module tb_core_seq_ctrl;

  localparam int unsigned COL  = 8;
  localparam int unsigned LEN  = 1024;
  localparam int unsigned MAXK = 9;
  localparam logic [10:0] WB   = 11'h400;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  num_kij;
  logic        l0_ready;
  logic        ofifo_valid;
  logic [49:0] inst;
  logic        busy;
  logic        done;
`ifdef CORE_SEQ_PERF_EN
  logic [15:0] stall_cnt;
  logic [23:0] run_cnt;
`endif

  core_seq_ctrl #(.col(COL), .len_nij(LEN), .max_kij(MAXK), .wbase(WB)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .num_kij(num_kij),
    .l0_ready(l0_ready),
    .ofifo_valid(ofifo_valid),
    .inst(inst),
    .busy(busy),
    .done(done)
`ifdef CORE_SEQ_PERF_EN
    ,
    .stall_cnt(stall_cnt),
    .run_cnt(run_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: expected xmem read addresses in order, expected
  // load/execute/mode patterns in order, and the expected psum write stream.
  logic [10:0] exp_addr[$];
  logic [2:0]  exp_lem[$];
  int          pm_next;
  int          pm_target;
  int          done_cnt;
  int          cyc;
  int          last_wr_cyc;
  bit          in_run;
  bit          mon_en;
  logic [49:0] h1, h2;
  logic [49:0] rv;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mon();
    logic [10:0] ea;
    logic [2:0]  el;
    logic        b;
    bit          exp_wr;
    if (!mon_en) return;
    chk("tied_bits", {inst[49], inst[32], inst[31:21], inst[19], inst[6:5]},
        {1'b0, 1'b1, 11'd0, 1'b1, 2'b00});
    b = ~h1[20];
    chk("l0_wr", inst[3], b);
    b = h1[3];
    chk("l0_rd", inst[4], b);
    if (inst[20] == 1'b0) begin
      chk("rd_expected", exp_addr.size() != 0, 1);
      if (exp_addr.size() != 0) begin
        ea = exp_addr.pop_front();
        chk("a0", inst[18:8], ea);
      end
    end
    if (inst[2:0] != 3'b000) begin
      chk("lem_expected", exp_lem.size() != 0, 1);
      if (exp_lem.size() != 0) begin
        el = exp_lem.pop_front();
        chk("lem", inst[2:0], el);
        b = h2[20];
        if (el == 3'b111) chk("flush_cen0", b, 1);
        else              chk("align_cen0", b, 0);
      end
    end
    exp_wr = in_run && ofifo_valid && (pm_next < pm_target);
    chk("pm_we", inst[48] == 1'b0, exp_wr);
    if (exp_wr) begin
      chk("pm_wen", inst[47], 0);
      chk("ofifo_rd", inst[7], 1);
      chk("a_pmem", inst[46:33], pm_next[13:0]);
      pm_next++;
      last_wr_cyc = cyc;
    end else begin
      chk("pm_idle", {inst[48], inst[47], inst[7]}, 3'b110);
    end
    if (done) done_cnt++;
    h2 = h1;
    h1 = inst;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    mon();
  endtask

  task automatic build_model(input int nk);
    int nkc;
    nkc = (nk > int'(MAXK)) ? int'(MAXK) : nk;
    exp_addr.delete();
    exp_lem.delete();
    for (int k = 0; k < nkc; k++) begin
      for (int r = 0; r < int'(COL); r++) begin
        exp_addr.push_back(11'(int'(WB) + k * int'(COL) + r));
        exp_lem.push_back(3'b001);
      end
      for (int r = 0; r < int'(LEN); r++) begin
        exp_addr.push_back(11'(r));
        exp_lem.push_back(3'b010);
      end
      exp_lem.push_back(3'b111);
    end
    pm_next   = 0;
    pm_target = int'(LEN) * nkc;
    done_cnt  = 0;
    last_wr_cyc = -1;
  endtask

  // smode: 0 no stall, 1 l0_ready low for WLOAD cycles 3..7, 2 random
  // omode: 0 ofifo_valid held high, 1 random
  // inj:   cycle index at which a start is pulsed while busy (0 = none)
  task automatic run(input int nk, input int smode, input int omode, input int inj);
    bit seen;
    build_model(nk);
    num_kij     = 4'(nk);
    start       = 1'b1;
    l0_ready    = 1'b1;
    ofifo_valid = 1'b0;
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    in_run = 1'b1;
    seen   = 1'b0;
    for (int j = 0; j < 40000 && !seen; j++) begin
      case (smode)
        0:       l0_ready = 1'b1;
        1:       l0_ready = !(j >= 3 && j <= 7);
        default: l0_ready = (j == 0) || ($urandom_range(0, 3) != 0);
      endcase
      ofifo_valid = (omode == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
      if (inj != 0 && j == inj) begin
        start   = 1'b1;
        num_kij = 4'd5;
      end
      tick();
      start = 1'b0;
      if (j == 0) chk("first_rd_cen0", inst[20], 0);
      if (smode == 1 && j >= 3 && j <= 7) chk("stall_cen0", inst[20], 1);
      if (done) begin
        seen = 1'b1;
        chk("busy_at_done", busy, 0);
        chk("done_after_last_pm", last_wr_cyc < cyc, 1);
`ifdef CORE_SEQ_PERF_EN
        if (smode == 1) chk("stall_cnt", stall_cnt, 5);
`endif
      end else begin
        chk("busy_in_run", busy, 1);
      end
    end
    in_run      = 1'b0;
    ofifo_valid = 1'b0;
    l0_ready    = 1'b1;
    chk("done_seen", seen, 1);
    repeat (4) tick();
    chk("done_once", done_cnt, 1);
    chk("rd_left", exp_addr.size(), 0);
    chk("lem_left", exp_lem.size(), 0);
    chk("pm_count", pm_next, pm_target);
  endtask

  initial begin
    rv = '0;
    rv[48] = 1'b1;
    rv[47] = 1'b1;
    rv[32] = 1'b1;
    rv[20] = 1'b1;
    rv[19] = 1'b1;
    reset       = 1'b0;
    start       = 1'b0;
    l0_ready    = 1'b0;
    ofifo_valid = 1'b0;
    num_kij     = 4'd0;
    mon_en      = 1'b0;
    in_run      = 1'b0;
    cyc         = 0;
    pm_next     = 0;
    pm_target   = 0;
    done_cnt    = 0;
    last_wr_cyc = -1;

    #12;
    chk("reset_inst", inst, rv);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
`ifdef CORE_SEQ_PERF_EN
    chk("reset_stall_cnt", stall_cnt, 0);
    chk("reset_run_cnt", run_cnt, 0);
`endif
    @(negedge clk);
    reset = 1'b1;
    h1 = inst;
    h2 = inst;
    mon_en = 1'b1;
    repeat (2) tick();

    // Two kernels, no stalls, psum beats every cycle
    run(2, 0, 0, 0);

    // Directed weight-load stall plus a start pulse while busy
    run(1, 1, 1, 60);

    // num_kij = 0: immediate done, nothing issued
    build_model(0);
    num_kij = 4'd0;
    start   = 1'b1;
    tick();
    start = 1'b0;
    chk("k0_done", done, 1);
    chk("k0_busy", busy, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("k0_idle_busy", busy, 0);
      chk("k0_idle_done", done, 0);
    end
    chk("k0_done_once", done_cnt, 1);

    // Reset in the middle of ACT
    build_model(1);
    num_kij  = 4'd1;
    l0_ready = 1'b1;
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("midrun_rst_inst", inst, rv);
    chk("midrun_rst_busy", busy, 0);
    chk("midrun_rst_done", done, 0);
    mon_en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    h1 = inst;
    h2 = inst;
    mon_en = 1'b1;
    repeat (3) tick();
    run(1, 0, 1, 0);

    // num_kij above the limit is clamped
    run(12, 0, 0, 0);

    // Randomized stalls and psum arrival
    run(int'($urandom_range(1, 3)), 2, 1, 0);
    run(int'($urandom_range(1, 3)), 2, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
